// File: rtl/mips_defs.sv
// Shared MIPS definitions: instruction field widths, opcode/funct constants,
// and the fetch FSM state encoding.
package mips_defs;

   localparam int OP_W     = 6;
   localparam int FUNCT_W  = 6;
   localparam int REG_W    = 5;
   localparam int IMM_W    = 16;

   localparam logic [5:0]  OP_RTYPE     = 6'h00;
   localparam logic [5:0]  OP_ADDI      = 6'h08;
   localparam logic [5:0]  FN_ADD       = 6'h20;
   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: update enable, next-PC mux and word-alignment check.
// A misaligned target is still taken, with its low two bits cleared.
module pc_reg
   import mips_defs::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write,
   input  logic             branch,
   input  logic             zero,
   input  logic             pc_src,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] pc,
   output logic             align_err
);

   logic             en;
   logic [WIDTH-1:0] nxt;

   assign en        = pc_write | (branch & zero);
   assign nxt       = pc_src ? alu_out : alu_result;
   assign align_err = en && (nxt[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (en) begin
         pc <= {nxt[WIDTH-1:2], 2'b00};
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC and IR, runs the memory read handshake and
// slices the IR into decode fields. All outputs are registered.
module instr_fetch_unit
   import mips_defs::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF[WIDTH-1:0],
   parameter int               MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write,
   input  logic             branch,
   input  logic             zero,
   input  logic             pc_src,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             ir_write,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] instr,
   output logic [5:0]       op,
   output logic [5:0]       funct,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [15:0]      imm,
   output logic             instr_valid,
   output logic             fetch_busy,
   output logic             fetch_err
);

   fetch_state_t     state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [WIDTH-1:0] ir_nxt, addr_nxt;
   logic             err_nxt;
   logic             align_err;

   pc_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .pc_write   (pc_write),
      .branch     (branch),
      .zero       (zero),
      .pc_src     (pc_src),
      .alu_result (alu_result),
      .alu_out    (alu_out),
      .pc         (pc),
      .align_err  (align_err)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         instr       <= '0;
         mem_addr    <= '0;
         mem_req     <= 1'b0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         instr       <= ir_nxt;
         mem_addr    <= addr_nxt;
         mem_req     <= (state_nxt == REQ) || (state_nxt == WAIT);
         instr_valid <= (state_nxt == DONE);
         fetch_err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ir_nxt    = instr;
      addr_nxt  = mem_addr;
      err_nxt   = fetch_err | align_err;
      case (state)
         IDLE: begin
            if (ir_write) begin
               addr_nxt  = pc;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               ir_nxt    = mem_rdata;
               state_nxt = DONE;
            end else begin
               cnt_nxt   = 4'd1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               ir_nxt    = mem_rdata;
               state_nxt = DONE;
            end else if (cnt == 4'(MAX_WAIT)) begin
               // Timed-out fetch delivers a NOP so control can keep running.
               ir_nxt    = NOP_WORD[WIDTH-1:0];
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (ir_write && (state != IDLE)) begin
         err_nxt = 1'b1;
      end
   end

   assign fetch_busy = mem_req;
   assign op         = instr[31:26];
   assign rs         = instr[25:21];
   assign rt         = instr[20:16];
   assign rd         = instr[15:11];
   assign imm        = instr[15:0];
   assign funct      = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, zero-wait and wait-state
// fetches, timeout, branch/alignment, overrun and reset mid-fetch.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write, branch, zero, pc_src, ir_write, mem_ready;
   logic [31:0] alu_result, alu_out, mem_rdata;
   logic        mem_req, instr_valid, fetch_busy, fetch_err;
   logic [31:0] mem_addr, pc, instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .branch(branch), .zero(zero),
      .pc_src(pc_src), .alu_result(alu_result), .alu_out(alu_out),
      .ir_write(ir_write), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .instr(instr),
      .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .instr_valid(instr_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      pc_write = 0; branch = 0; zero = 0; pc_src = 0; ir_write = 0; mem_ready = 0;
      alu_result = 0; alu_out = 0; mem_rdata = 0;
      do_reset();
      n_checks++; if (pc !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0040_0000); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", fetch_busy); end
   endtask

   task automatic test_zero_wait();
      ir_write = 1; pc_write = 1; pc_src = 0; alu_result = 32'h0040_0004;
      mem_rdata = 32'h2008_0005; mem_ready = 1;
      tick();
      ir_write = 0; pc_write = 0;
      n_checks++; if (mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL zw_mem_addr: got %h want %h", mem_addr, 32'h0040_0000); end
      n_checks++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL zw_pc: got %h want %h", pc, 32'h0040_0004); end
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req: got %b want 1", mem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid_early: got %b want 0", instr_valid); end
      tick();
      mem_ready = 0;
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", instr_valid); end
      n_checks++; if (op !== 6'h08) begin n_fail++; $display("FAIL zw_op: got %h want 08", op); end
      n_checks++; if (rt !== 5'd8) begin n_fail++; $display("FAIL zw_rt: got %0d want 8", rt); end
      n_checks++; if (imm !== 16'h0005) begin n_fail++; $display("FAIL zw_imm: got %h want 0005", imm); end
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy: got %b want 0", fetch_busy); end
      tick();
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid_pulse: got %b want 0", instr_valid); end
      n_checks++; if (instr !== 32'h2008_0005) begin n_fail++; $display("FAIL zw_ir_hold: got %h want %h", instr, 32'h2008_0005); end
   endtask

   task automatic test_wait_states();
      int busy_cycles = 0;
      int valid_at = -1;
      ir_write = 1; mem_ready = 0; mem_rdata = 32'h0109_5020;
      tick();
      ir_write = 0;
      for (int k = 0; k < 8; k++) begin
         if (fetch_busy) busy_cycles++;
         if (instr_valid && valid_at < 0) valid_at = k;
         mem_ready = (k == 3);
         tick();
      end
      mem_ready = 0;
      n_checks++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL ws_busy_cycles: got %0d want 4", busy_cycles); end
      n_checks++; if (valid_at !== 4) begin n_fail++; $display("FAIL ws_valid_cycle: got %0d want 4", valid_at); end
      n_checks++; if (mem_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL ws_mem_addr: got %h want %h", mem_addr, 32'h0040_0004); end
      n_checks++; if (op !== 6'h00) begin n_fail++; $display("FAIL ws_op: got %h want 00", op); end
      n_checks++; if (funct !== 6'h20) begin n_fail++; $display("FAIL ws_funct: got %h want 20", funct); end
      n_checks++; if (rd !== 5'd10) begin n_fail++; $display("FAIL ws_rd: got %0d want 10", rd); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL ws_err: got %b want 0", fetch_err); end
   endtask

   task automatic test_timeout();
      int busy_cycles = 0;
      int valid_at = -1;
      ir_write = 1; mem_ready = 0;
      tick();
      ir_write = 0;
      for (int k = 0; k < 24; k++) begin
         if (fetch_busy) busy_cycles++;
         if (instr_valid && valid_at < 0) valid_at = k;
         tick();
      end
      n_checks++; if (busy_cycles !== 16) begin n_fail++; $display("FAIL to_busy_cycles: got %0d want 16", busy_cycles); end
      n_checks++; if (valid_at !== 16) begin n_fail++; $display("FAIL to_valid_cycle: got %0d want 16", valid_at); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL to_instr: got %h want 0", instr); end
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", fetch_err); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL to_idle_req: got %b want 0", mem_req); end
   endtask

   task automatic test_branch();
      do_reset();
      branch = 1; zero = 1; pc_src = 1; alu_out = 32'h0040_0020; alu_result = 32'h0000_1000;
      tick();
      n_checks++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL br_taken: got %h want %h", pc, 32'h0040_0020); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL br_err_clean: got %b want 0", fetch_err); end
      zero = 0; alu_out = 32'h0040_0040;
      tick();
      n_checks++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL br_not_taken: got %h want %h", pc, 32'h0040_0020); end
      zero = 1; alu_out = 32'h0040_0022;
      tick();
      branch = 0; zero = 0; pc_src = 0;
      n_checks++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL br_misalign_pc: got %h want %h", pc, 32'h0040_0020); end
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL br_misalign_err: got %b want 1", fetch_err); end
   endtask

   task automatic test_overrun();
      do_reset();
      ir_write = 1; mem_ready = 0;
      tick();
      ir_write = 0; pc_write = 1; pc_src = 0; alu_result = 32'h0040_0010;
      tick();
      pc_write = 0;
      n_checks++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL ov_pc_while_busy: got %h want %h", pc, 32'h0040_0010); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL ov_err_before: got %b want 0", fetch_err); end
      ir_write = 1;
      tick();
      ir_write = 0;
      n_checks++; if (mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL ov_mem_addr: got %h want %h", mem_addr, 32'h0040_0000); end
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL ov_err: got %b want 1", fetch_err); end
      n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL ov_still_busy: got %b want 1", fetch_busy); end
      mem_ready = 1; mem_rdata = 32'h8C09_0004;
      tick();
      mem_ready = 0;
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ov_valid: got %b want 1", instr_valid); end
      n_checks++; if (instr !== 32'h8C09_0004) begin n_fail++; $display("FAIL ov_instr: got %h want %h", instr, 32'h8C09_0004); end
      tick();
      tick();
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL ov_no_new_fetch: got %b want 0", fetch_busy); end
   endtask

   task automatic test_reset_in_wait();
      ir_write = 1; mem_ready = 0;
      tick();
      ir_write = 0;
      tick();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req_before: got %b want 1", mem_req); end
      rst = 0;
      tick();
      rst = 1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req: got %b want 0", mem_req); end
      n_checks++; if (pc !== 32'h0040_0000) begin n_fail++; $display("FAIL rw_pc: got %h want %h", pc, 32'h0040_0000); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rw_instr: got %h want 0", instr); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rw_err: got %b want 0", fetch_err); end
      mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ready = 0;
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rw_late_ready_ir: got %h want 0", instr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_ready_valid: got %b want 0", instr_valid); end
      tick();
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_valid2: got %b want 0", instr_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_timeout();
      test_branch();
      test_overrun();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
